gsensor_spi_responder: RTL and testbench

SPI slave model of the on-board accelerometer, the responding end of the `gsensor` SPI bus (MISO/MOSI/SCLK/SS_n) driven by the system's SPI master. It oversamples the bus with the system clock, decodes the accelerometer's single- and multi-byte register protocol, and serves a 64-entry register file. Host-side ports load axis samples and report register writes. It is used in simulation and in loop-back builds where the real sensor is absent.

---
 rtl/gsensor_spi_pkg.sv | 20 ++
 rtl/spi_input_sync.sv | 32 +++
 rtl/gsensor_spi_responder.sv | 197 +++++++++++++++++++
 tb/tb_gsensor_spi_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_spi_pkg.sv
// Shared types and address map for the accelerometer SPI responder.
// Register 0x00 and the six axis sample registers are never writable from SPI.
package gsensor_spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } spi_state_t;

   localparam logic [5:0] ADDR_DEVID  = 6'h00;
   localparam logic [5:0] ADDR_DATAX0 = 6'h32;
   localparam logic [5:0] ADDR_DATAZ1 = 6'h37;

   function automatic logic is_read_only(input logic [5:0] addr);
      return (addr == ADDR_DEVID) || ((addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1));
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// N-stage input synchronizer with one-cycle rise/fall strobes on the synchronized level.
// INIT is the idle level of the pin, so no spurious edge appears after reset.
module spi_input_sync #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] stage_reg;
   logic              prev_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_reg <= {STAGES{INIT}};
         prev_reg  <= INIT;
      end else begin
         stage_reg <= {stage_reg[STAGES-2:0], din};
         prev_reg  <= stage_reg[STAGES-1];
      end
   end

   assign sync = stage_reg[STAGES-1];
   assign rise = sync & ~prev_reg;
   assign fall = ~sync & prev_reg;

endmodule

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 slave standing in for the accelerometer: decodes the command/data byte
// protocol, serves a 64x8 register file and accepts axis samples from the host side.
module gsensor_spi_responder
   import gsensor_spi_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DEVID       = 8'hE5
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic        gsensor_SCLK,
   input  logic        gsensor_MOSI,
   input  logic        gsensor_SS_n,
   output logic        gsensor_MISO,
   output logic        gsensor_MISO_oe,
   input  logic [47:0] axis_data,
   input  logic        axis_load,
   output logic        wr_valid,
   output logic [5:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy
);

   localparam int AX0 = int'(ADDR_DATAX0);
   localparam int AZ1 = int'(ADDR_DATAZ1);

   logic unused_sclk_level, sclk_rise, sclk_fall;
   logic ss_sync, ss_rise, ss_fall;
   logic mosi_sync, unused_mosi_rise, unused_mosi_fall;

   spi_input_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_sclk (
      .clk(clk_clk), .rst(reset_reset), .din(gsensor_SCLK),
      .sync(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall));
   spi_input_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_ss (
      .clk(clk_clk), .rst(reset_reset), .din(gsensor_SS_n),
      .sync(ss_sync), .rise(ss_rise), .fall(ss_fall));
   spi_input_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_mosi (
      .clk(clk_clk), .rst(reset_reset), .din(gsensor_MOSI),
      .sync(mosi_sync), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

   spi_state_t  state_reg, state_next;
   logic [2:0]  bit_cnt_reg;
   logic [6:0]  rx_shift_reg;
   logic [7:0]  tx_shift_reg;
   logic        rw_reg, mb_reg;
   logic [5:0]  addr_reg;
   logic        miso_reg, busy_reg;
   logic        wr_pend_reg;
   logic [5:0]  wr_pend_addr_reg, wr_addr_reg;
   logic [7:0]  wr_pend_data_reg, wr_data_reg;
   logic        wr_valid_reg;
   logic        axis_pend_reg;
   logic [47:0] axis_buf_reg;
   logic [7:0]  regs [64];

   logic        cmd_end, data_end, shift_out;
   logic [7:0]  rx_byte;
   logic [5:0]  next_addr;
   logic        axis_we;
   logic [47:0] axis_wdata;

   assign rx_byte   = {rx_shift_reg, mosi_sync};
   assign next_addr = addr_reg + 6'd1;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) state_reg <= ST_IDLE;
      else             state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (ss_rise) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: if (ss_fall) state_next = ST_CMD;
            ST_CMD:  if (cmd_end) state_next = ST_DATA;
            ST_DATA: if (data_end && !mb_reg) state_next = ST_DONE;
            default: ;
         endcase
      end
   end

   // Byte boundaries are suppressed when SS_n deasserts in the same cycle.
   always_comb begin
      cmd_end   = 1'b0;
      data_end  = 1'b0;
      shift_out = (state_reg == ST_DATA) || (state_reg == ST_DONE);
      if (sclk_rise && (bit_cnt_reg == 3'd7) && !ss_rise) begin
         cmd_end  = (state_reg == ST_CMD);
         data_end = (state_reg == ST_DATA);
      end
   end

   always_comb begin
      axis_we    = 1'b0;
      axis_wdata = axis_buf_reg;
      if (axis_load && !busy_reg) begin
         axis_we    = 1'b1;
         axis_wdata = axis_data;
      end else if (!axis_load && axis_pend_reg && !busy_reg) begin
         axis_we = 1'b1;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         bit_cnt_reg      <= 3'd0;
         rx_shift_reg     <= 7'd0;
         tx_shift_reg     <= 8'd0;
         rw_reg           <= 1'b0;
         mb_reg           <= 1'b0;
         addr_reg         <= 6'd0;
         miso_reg         <= 1'b0;
         busy_reg         <= 1'b0;
         wr_pend_reg      <= 1'b0;
         wr_pend_addr_reg <= 6'd0;
         wr_pend_data_reg <= 8'd0;
         wr_valid_reg     <= 1'b0;
         wr_addr_reg      <= 6'd0;
         wr_data_reg      <= 8'd0;
         axis_pend_reg    <= 1'b0;
         axis_buf_reg     <= 48'd0;
      end else begin
         wr_pend_reg <= 1'b0;
         if (state_reg == ST_IDLE || ss_fall) bit_cnt_reg <= 3'd0;
         else if (sclk_rise)                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
         if (sclk_rise) rx_shift_reg <= rx_byte[6:0];

         if (cmd_end) begin
            rw_reg       <= rx_byte[7];
            mb_reg       <= rx_byte[6];
            addr_reg     <= rx_byte[5:0];
            tx_shift_reg <= regs[rx_byte[5:0]];
         end else if (data_end) begin
            if (!rw_reg && !is_read_only(addr_reg)) begin
               wr_pend_reg      <= 1'b1;
               wr_pend_addr_reg <= addr_reg;
               wr_pend_data_reg <= rx_byte;
            end
            if (mb_reg) begin
               addr_reg     <= next_addr;
               tx_shift_reg <= regs[next_addr];
            end else begin
               tx_shift_reg <= 8'd0;
            end
         end else if (sclk_fall && shift_out) begin
            tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
         end

         if (!shift_out)     miso_reg <= 1'b0;
         else if (sclk_fall) miso_reg <= tx_shift_reg[7];

         busy_reg     <= ~ss_sync;
         wr_valid_reg <= wr_pend_reg;
         if (wr_pend_reg) begin
            wr_addr_reg <= wr_pend_addr_reg;
            wr_data_reg <= wr_pend_data_reg;
         end

         // Loads during a transfer are deferred so a burst read sees one coherent sample.
         if (axis_load && busy_reg) begin
            axis_buf_reg  <= axis_data;
            axis_pend_reg <= 1'b1;
         end else if (axis_we) begin
            axis_pend_reg <= 1'b0;
         end
      end
   end

   assign regs[0] = DEVID;

   for (genvar gi = 1; gi < 64; gi++) begin : g_reg
      logic [7:0] reg_q;
      if (gi >= AX0 && gi <= AZ1) begin : g_axis
         always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset)  reg_q <= 8'h00;
            else if (axis_we) reg_q <= axis_wdata[(gi-AX0)*8 +: 8];
         end
      end else begin : g_rw
         localparam logic [5:0] ADDR = 6'(gi);
         always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset)                                 reg_q <= 8'h00;
            else if (wr_pend_reg && wr_pend_addr_reg == ADDR) reg_q <= wr_pend_data_reg;
         end
      end
      assign regs[gi] = reg_q;
   end

   assign gsensor_MISO    = miso_reg;
   assign gsensor_MISO_oe = busy_reg;
   assign busy            = busy_reg;
   assign wr_valid        = wr_valid_reg;
   assign wr_addr         = wr_addr_reg;
   assign wr_data         = wr_data_reg;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Directed and randomized SPI mode-3 transfers against a byte-level register model.
module tb_gsensor_spi_responder;

   localparam int S    = 2;
   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b1, mosi = 1'b1, ss_n = 1'b1;
   logic        miso, miso_oe;
   logic [47:0] axis_data = 48'd0;
   logic        axis_load = 1'b0;
   logic        wr_valid;
   logic [5:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        busy;

   gsensor_spi_responder #(.SYNC_STAGES(S), .DEVID(8'hE5)) dut (
      .clk_clk(clk), .reset_reset(rst),
      .gsensor_SCLK(sclk), .gsensor_MOSI(mosi), .gsensor_SS_n(ss_n),
      .gsensor_MISO(miso), .gsensor_MISO_oe(miso_oe),
      .axis_data(axis_data), .axis_load(axis_load),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // Write-port monitor: logs every cycle wr_valid is seen high.
   int   wr_log_addr[$], wr_log_data[$], wr_log_cyc[$];
   int   wide_cnt = 0;
   logic wr_prev = 1'b0;
   always @(negedge clk) begin
      if (wr_valid === 1'b1) begin
         wr_log_addr.push_back(int'(wr_addr));
         wr_log_data.push_back(int'(wr_data));
         wr_log_cyc.push_back(cyc);
         if (wr_prev === 1'b1) wide_cnt <= wide_cnt + 1;
      end
      wr_prev <= wr_valid;
   end

   // Reference model: register contents and pending axis sample.
   logic [7:0] mregs [64];
   logic [7:0] exp_rx [16];
   int         exp_wa[$], exp_wd[$];
   logic [7:0] tx_b [16];
   logic [7:0] rx_b [16];
   int         last_rise_cyc;

   function automatic bit ro(input int a);
      return (a == 0) || (a >= 'h32 && a <= 'h37);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
      mregs[0] = 8'hE5;
   endtask

   task automatic model_axis(input logic [47:0] v);
      for (int k = 0; k < 6; k++) mregs['h32 + k] = v[8*k +: 8];
   endtask

   task automatic model_xfer(input int nfull);
      logic [7:0] cmd;
      int a;
      cmd = tx_b[0];
      a = int'(cmd[5:0]);
      exp_rx[0] = 8'h00;
      for (int i = 1; i < nfull; i++) begin
         if (!cmd[6] && i > 1) begin
            exp_rx[i] = 8'h00;
            continue;
         end
         exp_rx[i] = mregs[a];
         if (!cmd[7] && !ro(a)) begin
            mregs[a] = tx_b[i];
            exp_wa.push_back(a);
            exp_wd.push_back(int'(tx_b[i]));
         end
         if (cmd[6]) a = (a + 1) % 64;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic axis_idle_load(input logic [47:0] v);
      @(negedge clk);
      axis_data = v;
      axis_load = 1'b1;
      @(negedge clk);
      axis_load = 1'b0;
      @(negedge clk);
      model_axis(v);
   endtask

   // Mode-3 master: MOSI changes on SCLK fall, MISO sampled just before SCLK rise.
   task automatic spi_xfer(input int nbytes, input int abort_bits, input int load_after,
                           input logic [47:0] load_val);
      int total;
      total = (abort_bits >= 0) ? (nbytes - 1) * 8 + abort_bits : nbytes * 8;
      @(negedge clk);
      ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
      check("busy during transfer", busy, 1'b1);
      check("miso_oe during transfer", miso_oe, 1'b1);
      for (int k = 0; k < total; k++) begin
         sclk = 1'b0;
         mosi = tx_b[k / 8][7 - (k % 8)];
         repeat (HALF) @(negedge clk);
         rx_b[k / 8][7 - (k % 8)] = miso;
         sclk = 1'b1;
         last_rise_cyc = cyc;
         repeat (HALF) @(negedge clk);
         if ((k % 8) == 7 && (k / 8) + 1 == load_after) begin
            axis_data = load_val;
            axis_load = 1'b1;
            @(negedge clk);
            axis_load = 1'b0;
         end
      end
      ss_n = 1'b1;
      mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      check("busy after transfer", busy, 1'b0);
      check("miso_oe after transfer", miso_oe, 1'b0);
   endtask

   task automatic run_xfer(input int nbytes, input int abort_bits, input int load_after,
                           input logic [47:0] load_val);
      int nfull;
      nfull = (abort_bits >= 0) ? nbytes - 1 : nbytes;
      model_xfer(nfull);
      spi_xfer(nbytes, abort_bits, load_after, load_val);
      if (load_after > 0) model_axis(load_val);
      for (int j = 0; j < nfull; j++)
         check($sformatf("cmd %02h rx byte %0d", tx_b[0], j), rx_b[j], exp_rx[j]);
      check($sformatf("cmd %02h write count", tx_b[0]), wr_log_addr.size(), exp_wa.size());
      while (exp_wa.size() > 0 && wr_log_addr.size() > 0) begin
         check("wr_addr", wr_log_addr.pop_front(), exp_wa.pop_front());
         check("wr_data", wr_log_data.pop_front(), exp_wd.pop_front());
      end
      exp_wa.delete(); exp_wd.delete();
      wr_log_addr.delete(); wr_log_data.delete(); wr_log_cyc.delete();
      $display("xfer cmd=%02h bytes=%0d abort=%0d load_after=%0d", tx_b[0], nbytes, abort_bits, load_after);
   endtask

   initial begin
      int n, ab, la;
      logic [47:0] lv;
      model_reset();
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset miso", miso, 1'b0);
      check("reset miso_oe", miso_oe, 1'b0);
      check("reset wr_valid", wr_valid, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset wr_addr", wr_addr, 6'd0);
      check("reset wr_data", wr_data, 8'd0);

      // busy latency: SYNC_STAGES+1 clocks after SS_n falls
      ss_n = 1'b0;
      repeat (S) @(negedge clk);
      check("busy before latency", busy, 1'b0);
      @(negedge clk);
      check("busy at latency", busy, 1'b1);
      ss_n = 1'b1;
      repeat (HALF) @(negedge clk);

      tx_b[0] = 8'h80;
      run_xfer(2, -1, 0, 48'd0);
      check("devid read", rx_b[1], 8'hE5);

      // Single write, also checks wr_valid latency from the last data-bit SCLK rise
      tx_b[0] = 8'h31; tx_b[1] = 8'h0B;
      model_xfer(2);
      spi_xfer(2, -1, 0, 48'd0);
      check("write 31 pulse count", wr_log_addr.size(), 1);
      if (wr_log_addr.size() == 1) begin
         check("write 31 addr", wr_log_addr[0], 'h31);
         check("write 31 data", wr_log_data[0], 'h0B);
         check("wr_valid latency", wr_log_cyc[0] - last_rise_cyc, S + 2);
      end
      exp_wa.delete(); exp_wd.delete();
      wr_log_addr.delete(); wr_log_data.delete(); wr_log_cyc.delete();
      tx_b[0] = 8'hB1;
      run_xfer(2, -1, 0, 48'd0);
      check("readback 31", rx_b[1], 8'h0B);

      axis_idle_load(48'h0605_0403_0201);
      tx_b[0] = 8'hF2;
      run_xfer(7, -1, 0, 48'd0);
      for (int j = 1; j <= 6; j++) check($sformatf("axis byte %0d", j), rx_b[j], 8'(j));

      run_xfer(7, -1, 3, 48'hAAAA_AAAA_AAAA);
      for (int j = 3; j <= 6; j++) check($sformatf("coherent byte %0d", j), rx_b[j], 8'(j));
      run_xfer(7, -1, 0, 48'd0);
      for (int j = 1; j <= 6; j++) check($sformatf("new axis byte %0d", j), rx_b[j], 8'hAA);

      tx_b[0] = 8'h1E; tx_b[1] = 8'h55;
      run_xfer(2, 5, 0, 48'd0);
      tx_b[0] = 8'h9E;
      run_xfer(2, -1, 0, 48'd0);
      check("aborted write left 1E", rx_b[1], 8'h00);

      tx_b[0] = 8'h7F; tx_b[1] = 8'h11; tx_b[2] = 8'h22;
      run_xfer(3, -1, 0, 48'd0);
      tx_b[0] = 8'h3E; tx_b[1] = 8'h33; tx_b[2] = 8'h44;
      run_xfer(3, -1, 0, 48'd0);
      tx_b[0] = 8'hFE;
      run_xfer(4, -1, 0, 48'd0);
      check("reg 3E", rx_b[1], 8'h33);
      check("reg 3F", rx_b[2], 8'h11);
      check("reg 00 after wrap", rx_b[3], 8'hE5);

      for (int t = 0; t < 24; t++) begin
         n  = $urandom_range(1, 5);
         ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : -1;
         la = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
         if (ab >= 0 && la >= n) la = 0;
         lv = {$urandom, $urandom};
         for (int j = 0; j < n; j++) tx_b[j] = 8'($urandom);
         if ($urandom_range(0, 4) == 0) axis_idle_load({$urandom, $urandom});
         run_xfer(n, ab, la, lv);
      end

      check("wr_valid single-cycle", wide_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
